// File: rtl/tdm_demux_sequencer_pkg.sv
// Shared types, constants and mask helpers for the TDM demux sequencer.
// Holds the state enum, sizing constants and set-bit search functions.
package tdm_demux_sequencer_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;
    localparam int CNTW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT  = 2'd1,
        GUARD = 2'd2
    } state_t;

    typedef struct packed {
        logic            found;
        logic [SELW-1:0] idx;
    } bitpos_t;

    // Lowest set bit strictly above cur; found=0 when none exists.
    function automatic bitpos_t next_above(input logic [NCH-1:0] mask,
                                           input logic [SELW-1:0] cur);
        bitpos_t r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.found = 1'b1;
                r.idx   = SELW'(i);
            end
        end
        return r;
    endfunction

    // Lowest set bit of the mask; found=0 for an empty mask.
    function automatic bitpos_t lowest_set(input logic [NCH-1:0] mask);
        bitpos_t r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = SELW'(i);
            end
        end
        return r;
    endfunction

    // A programmed dwell of 0 still gives a one-cycle slot.
    function automatic logic [CNTW-1:0] dwell_len(input logic [CNTW-1:0] d);
        return (d == '0) ? CNTW'(1) : d;
    endfunction

endpackage

// File: rtl/tdm_demux_sequencer_demux.sv
// Combinational 1-to-8 demux: out[sel] = in when en, all other bits 0.
// Ports: in (serial data), en (enable), sel (select), out (8 outputs).
module tdm_demux_sequencer_demux
    import tdm_demux_sequencer_pkg::*;
(
    input  logic            in,
    input  logic            en,
    input  logic [SELW-1:0] sel,
    output logic [NCH-1:0]  out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[sel] = in;
        end
    end

endmodule

// File: rtl/tdm_demux_sequencer.sv
// Time-division sequencer stepping a 1-to-8 demux through masked channels.
// Ports: clk, rst (async high), start, stop, loop, chan_mask, dwell, guard,
// data_in; outputs data_out, demux_en, demux_sel, busy, slot_start,
// frame_done, cfg_err.
module tdm_demux_sequencer
    import tdm_demux_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            loop,
    input  logic [NCH-1:0]  chan_mask,
    input  logic [CNTW-1:0] dwell,
    input  logic [CNTW-1:0] guard,
    input  logic            data_in,
    output logic [NCH-1:0]  data_out,
    output logic            demux_en,
    output logic [SELW-1:0] demux_sel,
    output logic            busy,
    output logic            slot_start,
    output logic            frame_done,
    output logic            cfg_err
);

    state_t          state, state_nxt;
    logic [SELW-1:0] sel, sel_nxt;
    logic [SELW-1:0] pend, pend_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [NCH-1:0]  sh_mask, sh_mask_nxt;
    logic [CNTW-1:0] sh_dwell, sh_dwell_nxt;
    logic [CNTW-1:0] sh_guard, sh_guard_nxt;
    logic            sh_loop, sh_loop_nxt;
    logic            stop_q, stop_nxt;
    logic            cfg_q, cfg_nxt;

    bitpos_t nb;
    bitpos_t lo_live;
    logic    stop_any;
    logic    last_cyc;

    assign nb       = next_above(sh_mask, sel);
    assign lo_live  = lowest_set(chan_mask);
    // A stop arriving on the final cycle of a period still ends the run.
    assign stop_any = stop_q | stop;
    assign last_cyc = (cnt == CNTW'(1));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            pend     <= '0;
            cnt      <= '0;
            sh_mask  <= '0;
            sh_dwell <= '0;
            sh_guard <= '0;
            sh_loop  <= 1'b0;
            stop_q   <= 1'b0;
            cfg_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            pend     <= pend_nxt;
            cnt      <= cnt_nxt;
            sh_mask  <= sh_mask_nxt;
            sh_dwell <= sh_dwell_nxt;
            sh_guard <= sh_guard_nxt;
            sh_loop  <= sh_loop_nxt;
            stop_q   <= stop_nxt;
            cfg_q    <= cfg_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        pend_nxt     = pend;
        cnt_nxt      = cnt;
        sh_mask_nxt  = sh_mask;
        sh_dwell_nxt = sh_dwell;
        sh_guard_nxt = sh_guard;
        sh_loop_nxt  = sh_loop;
        cfg_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (lo_live.found) begin
                        sh_mask_nxt  = chan_mask;
                        sh_dwell_nxt = dwell;
                        sh_guard_nxt = guard;
                        sh_loop_nxt  = loop;
                        sel_nxt      = lo_live.idx;
                        cnt_nxt      = dwell_len(dwell);
                        state_nxt    = SLOT;
                    end else begin
                        cfg_nxt = 1'b1;
                    end
                end
            end
            SLOT: begin
                if (!last_cyc) begin
                    cnt_nxt = cnt - CNTW'(1);
                end else if (stop_any) begin
                    state_nxt = IDLE;
                end else if (nb.found) begin
                    if (sh_guard != '0) begin
                        state_nxt = GUARD;
                        cnt_nxt   = sh_guard;
                        pend_nxt  = nb.idx;
                    end else begin
                        sel_nxt = nb.idx;
                        cnt_nxt = dwell_len(sh_dwell);
                    end
                end else if (sh_loop) begin
                    // Frame boundary of a looping run: fresh snapshot.
                    sh_mask_nxt  = chan_mask;
                    sh_dwell_nxt = dwell;
                    sh_guard_nxt = guard;
                    sh_loop_nxt  = loop;
                    if (!lo_live.found) begin
                        state_nxt = IDLE;
                        cfg_nxt   = 1'b1;
                    end else if (guard != '0) begin
                        state_nxt = GUARD;
                        cnt_nxt   = guard;
                        pend_nxt  = lo_live.idx;
                    end else begin
                        sel_nxt = lo_live.idx;
                        cnt_nxt = dwell_len(dwell);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            GUARD: begin
                if (!last_cyc) begin
                    cnt_nxt = cnt - CNTW'(1);
                end else if (stop_any) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SLOT;
                    sel_nxt   = pend;
                    cnt_nxt   = dwell_len(sh_dwell);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == IDLE) begin
            stop_nxt = 1'b0;
        end else begin
            stop_nxt = stop_q | (stop && (state != IDLE));
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        demux_en   = (state == SLOT);
        busy       = (state != IDLE);
        // The counter is reloaded with the full dwell on every slot entry.
        slot_start = (state == SLOT) && (cnt == dwell_len(sh_dwell));
        frame_done = (state == SLOT) && last_cyc && !nb.found;
    end

    assign demux_sel = sel;
    assign cfg_err   = cfg_q;

    tdm_demux_sequencer_demux u_demux (
        .in  (data_in),
        .en  (demux_en),
        .sel (demux_sel),
        .out (data_out)
    );

endmodule

// File: tb/tb_tdm_demux_sequencer.sv
// Scoreboard bench for tdm_demux_sequencer: a frame-plan reference model
// queues per-cycle expectations, a negedge monitor pops and compares.
module tb_tdm_demux_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] chan_mask;
    logic [7:0] dwell;
    logic [7:0] guard;
    logic       data_in;
    logic [7:0] data_out;
    logic       demux_en;
    logic [2:0] demux_sel;
    logic       busy;
    logic       slot_start;
    logic       frame_done;
    logic       cfg_err;

    tdm_demux_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .chan_mask  (chan_mask),
        .dwell      (dwell),
        .guard      (guard),
        .data_in    (data_in),
        .data_out   (data_out),
        .demux_en   (demux_en),
        .demux_sel  (demux_sel),
        .busy       (busy),
        .slot_start (slot_start),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int ch;
        bit en;
        bit first;
        bit pend;
        bit fdone;
    } ent_t;

    typedef struct {
        bit busy;
        bit en;
        int sel;
        bit ss;
        bit fd;
        bit cfg;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    ent_t plan[$];
    exp_t exq[$];
    bit   busy_m;
    bit   stop_m;
    bit   loop_m;
    int   sel_m;
    ent_t cur;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, req);
        end
    endfunction

    task automatic add_guard(input int ch, input logic [7:0] g);
        for (int k = 0; k < int'(g); k++)
            plan.push_back('{ch: ch, en: 1'b0, first: 1'b0,
                             pend: (k == int'(g) - 1), fdone: 1'b0});
    endtask

    // One frame: each masked channel for its dwell, guards between.
    task automatic build_frame(input logic [7:0] m, input logic [7:0] d,
                               input logic [7:0] g);
        int dl;
        int last;
        int prev;
        bit first_ch;
        dl = (d == 0) ? 1 : int'(d);
        last = 0;
        prev = 0;
        first_ch = 1'b1;
        for (int c = 0; c < 8; c++) if (m[c]) last = c;
        for (int c = 0; c < 8; c++) begin
            if (m[c]) begin
                if (!first_ch) add_guard(prev, g);
                for (int k = 0; k < dl; k++)
                    plan.push_back('{ch: c, en: 1'b1, first: (k == 0),
                                     pend: (k == dl - 1),
                                     fdone: (c == last && k == dl - 1)});
                prev = c;
                first_ch = 1'b0;
            end
        end
    endtask

    // Reference model: decides the cycle after each rising edge.
    initial begin
        exp_t e;
        bit   cfg;
        busy_m = 0;
        stop_m = 0;
        loop_m = 0;
        sel_m  = 0;
        forever begin
            @(posedge clk);
            cfg = 0;
            if (rst) begin
                plan.delete();
                busy_m = 0;
                stop_m = 0;
                sel_m  = 0;
            end else if (busy_m) begin
                if (stop) stop_m = 1;
                if (stop_m && cur.pend) begin
                    plan.delete();
                    busy_m = 0;
                end else if (plan.size() == 0) begin
                    if (loop_m) begin
                        loop_m = loop;
                        if (chan_mask == 0) begin
                            busy_m = 0;
                            cfg = 1;
                        end else begin
                            add_guard(cur.ch, guard);
                            build_frame(chan_mask, dwell, guard);
                        end
                    end else begin
                        busy_m = 0;
                    end
                end
            end else if (start) begin
                if (chan_mask == 0) begin
                    cfg = 1;
                end else begin
                    loop_m = loop;
                    build_frame(chan_mask, dwell, guard);
                    busy_m = 1;
                end
            end
            if (!busy_m) stop_m = 0;
            if (busy_m) begin
                cur = plan.pop_front();
                sel_m = cur.ch;
                e = '{busy: 1, en: cur.en, sel: cur.ch, ss: cur.first,
                      fd: cur.fdone, cfg: 0};
            end else begin
                e = '{busy: 0, en: 0, sel: sel_m, ss: 0, fd: 0, cfg: cfg};
            end
            exq.push_back(e);
        end
    end

    // Monitor: compares each presented cycle mid-period.
    initial begin
        exp_t e;
        int   dexp;
        forever begin
            @(negedge clk);
            if (exq.size() != 0) begin
                e = exq.pop_front();
                if (rst) e = '{busy: 0, en: 0, sel: 0, ss: 0, fd: 0, cfg: 0};
                dexp = e.en ? (int'(data_in) << e.sel) : 0;
                chk("busy", int'(busy), int'(e.busy));
                chk("demux_en", int'(demux_en), int'(e.en));
                chk("demux_sel", int'(demux_sel), e.sel);
                chk("data_out", int'(data_out), dexp);
                chk("slot_start", int'(slot_start), int'(e.ss));
                chk("frame_done", int'(frame_done), int'(e.fd));
                chk("cfg_err", int'(cfg_err), int'(e.cfg));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int wait_n;
        rst = 1; start = 0; stop = 0; loop = 0;
        chan_mask = 0; dwell = 0; guard = 0; data_in = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Empty mask start
        start = 1;
        cyc(1);
        start = 0;
        cyc(3);

        // 0x25 single frame with guards
        chan_mask = 8'h25; dwell = 3; guard = 2; loop = 0; data_in = 1;
        start = 1;
        cyc(1);
        start = 0;
        cyc(20);

        // 0x81 back-to-back looping, mask changed mid-frame
        chan_mask = 8'h81; dwell = 0; guard = 0; loop = 1;
        start = 1;
        cyc(1);
        start = 0;
        cyc(5);
        chan_mask = 8'h02;
        cyc(6);
        loop = 0;
        cyc(6);

        // Stop in 2nd cycle of channel 3
        chan_mask = 8'hFF; dwell = 4; guard = 2; loop = 1;
        start = 1;
        cyc(1);
        start = 0;
        wait_n = 0;
        while (!(demux_en && demux_sel == 3 && slot_start) && wait_n < 100) begin
            cyc(1);
            wait_n++;
        end
        chk("stop_slot_reached", wait_n < 100 ? 1 : 0, 1);
        cyc(1);
        stop = 1;
        cyc(1);
        stop = 0;
        cyc(8);

        // Asynchronous reset mid-slot
        chan_mask = 8'h3C; dwell = 5; guard = 1; loop = 1; data_in = 1;
        start = 1;
        cyc(1);
        start = 0;
        cyc(2);
        #2 rst = 1;
        #1;
        chk("async_en", int'(demux_en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_data", int'(data_out), 0);
        chk("async_sel", int'(demux_sel), 0);
        @(posedge clk);
        #1 rst = 0;
        loop = 0;
        start = 1;
        cyc(1);
        start = 0;
        cyc(30);

        // Start held high while busy
        chan_mask = 8'h5A; dwell = 2; guard = 1; loop = 0;
        start = 1;
        cyc(40);
        start = 0;
        cyc(20);

        // Longest dwell
        chan_mask = 8'h10; dwell = 255; guard = 0; loop = 0;
        start = 1;
        cyc(1);
        start = 0;
        cyc(260);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            data_in = 1'($urandom);
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                chan_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                dwell = 8'($urandom_range(0, 3));
                guard = 8'($urandom_range(0, 2));
                loop = 1'($urandom);
            end
            cyc(1);
        end
        start = 0;
        stop = 0;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
